postfix_term_evaluator: RTL and testbench

Parametrised postfix (RPN) term evaluator: the next generation of the term accumulator, with a configurable-depth internal operand stack. It consumes a token stream (operands already decoded to values, operators as 5-bit codes) and dispatches arithmetic to the shared floating-point ALU over a start/done handshake. Subtraction is issued as an add with the sign of operand b flipped. It returns one result per term, with stack-fault detection.

---
 rtl/postfix_term_evaluator.sv | 219 +++++++++++++++++++++
 tb/tb_postfix_term_evaluator.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/postfix_term_evaluator.sv
// Postfix (RPN) term evaluator with an internal operand stack and a start/done ALU handshake.
// Optional DUP/SWAP stack operators are built when POSTFIX_STACK_OPS_EN is defined.
module postfix_term_evaluator #(
    parameter int DATA_WIDTH  = 32,
    parameter int STACK_DEPTH = 8,
    parameter int DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tok_valid,
    output logic                  tok_ready,
    input  logic                  tok_is_op,
    input  logic [4:0]            tok_code,
    input  logic [DATA_WIDTH-1:0] tok_value,
    input  logic                  tok_last,
    output logic                  alu_start,
    output logic [1:0]            alu_op,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic                  alu_done,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  res_valid,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_error,
    output logic [1:0]            res_err_code,
    output logic [DEPTH_W-1:0]    depth
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [DEPTH_W-1:0] FULL = DEPTH_W'(STACK_DEPTH);
    localparam logic [DEPTH_W-1:0] TWO  = DEPTH_W'(2);

    localparam logic [4:0] OP_MULT = 5'b10000;
    localparam logic [4:0] OP_ADD  = 5'b10001;
    localparam logic [4:0] OP_SUB  = 5'b10010;
    localparam logic [4:0] OP_DIV  = 5'b10011;
    localparam logic [4:0] OP_EXP  = 5'b10100;
`ifdef POSTFIX_STACK_OPS_EN
    localparam logic [4:0] OP_DUP  = 5'b10101;
    localparam logic [4:0] OP_SWAP = 5'b10110;
`endif

    typedef enum logic [2:0] {
        S_ACCEPT, S_ISSUE, S_WAIT_ALU, S_DRAIN, S_DONE
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'b00,
        ERR_UNDERFLOW = 2'b01,
        ERR_OVERFLOW  = 2'b10,
        ERR_MALFORMED = 2'b11
    } err_t;

    state_t state, state_next;
    err_t   fault, fault_next, done_code;
    logic   armed, last_pending;
    logic   accept, push_en, swap_en, alu_wb, issue_en, fault_set, clear;

    logic [DATA_WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic [DATA_WIDTH-1:0] push_data, tos, nos;
    logic [IDX_W-1:0]      tos_idx, nos_idx;

    assign tos_idx = IDX_W'(depth - DEPTH_W'(1));
    assign nos_idx = IDX_W'(depth - TWO);
    assign tos     = stack_mem[tos_idx];
    assign nos     = stack_mem[nos_idx];

    // armed keeps tok_ready low until the first clock after reset is released.
    assign tok_ready = armed && (state == S_ACCEPT || state == S_DRAIN);
    assign alu_start = (state == S_ISSUE);
    assign accept    = tok_valid && tok_ready;

    function automatic logic [1:0] alu_op_of(input logic [4:0] code);
        case (code)
            OP_MULT:        return 2'b00;
            OP_ADD, OP_SUB: return 2'b01;
            OP_DIV:         return 2'b10;
            default:        return 2'b11;
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal gets a default here so no path can infer a latch.
        state_next = state;
        fault_next = ERR_NONE;
        fault_set  = 1'b0;
        push_en    = 1'b0;
        push_data  = tok_value;
        swap_en    = 1'b0;
        alu_wb     = 1'b0;
        issue_en   = 1'b0;
        clear      = 1'b0;

        case (state)
            S_ACCEPT: begin
                if (accept) begin
                    if (!tok_is_op) begin
                        if (depth == FULL) begin
                            fault_set  = 1'b1;
                            fault_next = ERR_OVERFLOW;
                        end else begin
                            push_en = 1'b1;
                        end
                    end else begin
                        case (tok_code)
                            OP_MULT, OP_ADD, OP_SUB, OP_DIV, OP_EXP: begin
                                if (depth < TWO) begin
                                    fault_set  = 1'b1;
                                    fault_next = ERR_UNDERFLOW;
                                end else begin
                                    issue_en = 1'b1;
                                end
                            end
`ifdef POSTFIX_STACK_OPS_EN
                            OP_DUP: begin
                                if (depth == '0) begin
                                    fault_set  = 1'b1;
                                    fault_next = ERR_UNDERFLOW;
                                end else if (depth == FULL) begin
                                    fault_set  = 1'b1;
                                    fault_next = ERR_OVERFLOW;
                                end else begin
                                    push_en   = 1'b1;
                                    push_data = tos;
                                end
                            end
                            OP_SWAP: begin
                                if (depth < TWO) begin
                                    fault_set  = 1'b1;
                                    fault_next = ERR_UNDERFLOW;
                                end else begin
                                    swap_en = 1'b1;
                                end
                            end
`endif
                            default: begin
                                fault_set  = 1'b1;
                                fault_next = ERR_MALFORMED;
                            end
                        endcase
                    end

                    if (fault_set)     state_next = tok_last ? S_DONE : S_DRAIN;
                    else if (issue_en) state_next = S_ISSUE;
                    else if (tok_last) state_next = S_DONE;
                end
            end
            S_ISSUE:    state_next = S_WAIT_ALU;
            S_WAIT_ALU: begin
                if (alu_done) begin
                    alu_wb     = 1'b1;
                    state_next = last_pending ? S_DONE : S_ACCEPT;
                end
            end
            S_DRAIN: begin
                if (accept && tok_last) state_next = S_DONE;
            end
            S_DONE: begin
                clear      = 1'b1;
                state_next = S_ACCEPT;
            end
            default: state_next = S_ACCEPT;
        endcase
    end

    // A term that ends without a fault must leave exactly one value behind.
    always_comb begin
        done_code = fault;
        if (fault == ERR_NONE && depth != DEPTH_W'(1)) done_code = ERR_MALFORMED;
        res_valid    = (state == S_DONE);
        res_error    = res_valid && (done_code != ERR_NONE);
        res_err_code = res_valid ? done_code : ERR_NONE;
        res_data     = (res_valid && done_code == ERR_NONE) ? stack_mem[0] : '0;
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!reset) begin
            state        <= S_ACCEPT;
            armed        <= 1'b0;
            depth        <= '0;
            fault        <= ERR_NONE;
            last_pending <= 1'b0;
            alu_op       <= 2'b00;
            alu_a        <= '0;
            alu_b        <= '0;
        end else begin
            state <= state_next;
            armed <= 1'b1;

            if (clear)        depth <= '0;
            else if (push_en) depth <= depth + DEPTH_W'(1);
            else if (alu_wb)  depth <= depth - DEPTH_W'(1);

            if (clear)                              fault <= ERR_NONE;
            else if (fault_set && fault == ERR_NONE) fault <= fault_next;

            if (issue_en) begin
                alu_op       <= alu_op_of(tok_code);
                alu_a        <= nos;
                alu_b        <= (tok_code == OP_SUB) ? {~tos[DATA_WIDTH-1], tos[DATA_WIDTH-2:0]} : tos;
                last_pending <= tok_last;
            end
        end
    end

    // NOTE: the stack storage has no reset; depth alone defines which entries are live.
    always_ff @(posedge clock) begin
        if (push_en) begin
            stack_mem[IDX_W'(depth)] <= push_data;
        end else if (swap_en) begin
            stack_mem[tos_idx] <= nos;
            stack_mem[nos_idx] <= tos;
        end else if (alu_wb) begin
            stack_mem[nos_idx] <= alu_result;
        end
    end

endmodule

// File: tb/tb_postfix_term_evaluator.sv
// Self-checking bench for postfix_term_evaluator: directed terms plus random token streams
// checked against a queue-based RPN reference model and a bench-side mock ALU.
`timescale 1ns/1ps
module tb_postfix_term_evaluator;

    localparam int DW   = 32;
    localparam int SD   = 4;
    localparam int DEPW = $clog2(SD + 1);

`ifdef POSTFIX_STACK_OPS_EN
    localparam bit STACK_OPS = 1'b1;
`else
    localparam bit STACK_OPS = 1'b0;
`endif

    localparam logic [DW-1:0] F2_0  = 32'h4000_0000;
    localparam logic [DW-1:0] F3_0  = 32'h4040_0000;
    localparam logic [DW-1:0] F4_0  = 32'h4080_0000;
    localparam logic [DW-1:0] F5_0  = 32'h40A0_0000;
    localparam logic [DW-1:0] F16_0 = 32'h4180_0000;
    localparam logic [DW-1:0] FN3_0 = 32'hC040_0000;
    localparam logic [DW-1:0] SIGN  = 32'h8000_0000;

    typedef struct packed {
        logic          is_op;
        logic [4:0]    code;
        logic [DW-1:0] value;
        logic          last;
    } tok_t;

    typedef struct packed {
        logic [1:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } launch_t;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            tok_valid = 1'b0, tok_ready, tok_is_op = 1'b0, tok_last = 1'b0;
    logic [4:0]      tok_code = '0;
    logic [DW-1:0]   tok_value = '0;
    logic            alu_start, alu_done = 1'b0;
    logic [1:0]      alu_op;
    logic [DW-1:0]   alu_a, alu_b, alu_result = '0;
    logic            res_valid, res_error;
    logic [DW-1:0]   res_data;
    logic [1:0]      res_err_code;
    logic [DEPW-1:0] depth;

    int n_checks = 0;
    int n_fail   = 0;

    tok_t          toks[$];
    launch_t       exp_launch[$];
    logic [DW-1:0] exp_data;
    logic [1:0]    exp_code;
    bit            exp_last_launch;

    postfix_term_evaluator #(.DATA_WIDTH(DW), .STACK_DEPTH(SD), .DEPTH_W(DEPW)) dut (
        .clock(clock), .reset(reset),
        .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_op(tok_is_op),
        .tok_code(tok_code), .tok_value(tok_value), .tok_last(tok_last),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result),
        .res_valid(res_valid), .res_data(res_data), .res_error(res_error),
        .res_err_code(res_err_code), .depth(depth)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bench-side ALU: a few genuine float results for the directed terms, a fixed mix otherwise.
    function automatic logic [DW-1:0] alu_model(input logic [1:0] op, input logic [DW-1:0] a,
                                                input logic [DW-1:0] b);
        if (op == 2'b01 && a == F2_0 && b == F3_0)  return F5_0;
        if (op == 2'b01 && a == F5_0 && b == FN3_0) return F2_0;
        if (op == 2'b00 && a == F4_0 && b == F4_0)  return F16_0;
        return (a * 32'd7) + b + DW'(op);
    endfunction

    function automatic bit is_arith(input tok_t t);
        return t.is_op && (t.code inside {[5'h10:5'h14]});
    endfunction

    task automatic push_opd(input logic [DW-1:0] v, input bit last);
        tok_t t;
        t.is_op = 1'b0; t.code = '0; t.value = v; t.last = last;
        toks.push_back(t);
    endtask

    task automatic push_op(input logic [4:0] c, input bit last);
        tok_t t;
        t.is_op = 1'b1; t.code = c; t.value = '0; t.last = last;
        toks.push_back(t);
    endtask

    // Reference: evaluate the token list on a queue stack; stop at the first fault.
    task automatic model_term();
        logic [DW-1:0] st[$];
        logic [DW-1:0] a, b;
        logic [1:0]    op;
        launch_t       l;
        exp_code = 2'b00;
        exp_last_launch = 1'b0;
        exp_launch.delete();
        foreach (toks[i]) begin
            if (exp_code != 2'b00) continue;
            if (!toks[i].is_op) begin
                if (st.size() == SD) exp_code = 2'b10;
                else st.push_back(toks[i].value);
            end else if (is_arith(toks[i])) begin
                if (st.size() < 2) exp_code = 2'b01;
                else begin
                    b = st.pop_back();
                    a = st.pop_back();
                    case (toks[i].code)
                        5'h10:        op = 2'b00;
                        5'h11, 5'h12: op = 2'b01;
                        5'h13:        op = 2'b10;
                        default:      op = 2'b11;
                    endcase
                    if (toks[i].code == 5'h12) b = b ^ SIGN;
                    l.op = op; l.a = a; l.b = b;
                    exp_launch.push_back(l);
                    st.push_back(alu_model(op, a, b));
                    if (i == toks.size() - 1) exp_last_launch = 1'b1;
                end
            end else if (STACK_OPS && toks[i].code == 5'h15) begin
                if (st.size() == 0)       exp_code = 2'b01;
                else if (st.size() == SD) exp_code = 2'b10;
                else st.push_back(st[st.size()-1]);
            end else if (STACK_OPS && toks[i].code == 5'h16) begin
                if (st.size() < 2) exp_code = 2'b01;
                else begin
                    b = st.pop_back();
                    a = st.pop_back();
                    st.push_back(b);
                    st.push_back(a);
                end
            end else begin
                exp_code = 2'b11;
            end
        end
        if (exp_code == 2'b00 && st.size() != 1) exp_code = 2'b11;
        exp_data = (exp_code == 2'b00) ? st[0] : '0;
    endtask

    // Drive one term, play the ALU with a fixed latency, and check launches and the result.
    task automatic run_term(input string name, input int lat);
        int            idx, cyc, acc_cyc, acc_last_cyc, done_cyc, cd, n_launch;
        bit            got, rdy, vld, chk_ready;
        logic [DW-1:0] pend;
        model_term();
        idx = 0; cyc = 0; cd = 0; n_launch = 0; got = 0; chk_ready = 0;
        acc_cyc = -10; acc_last_cyc = -10; done_cyc = -10; pend = '0;
        for (int budget = 0; budget < 200 && !got; budget++) begin
            if (chk_ready) begin
                check({name, " ready_after_tok"}, tok_ready, 1);
                chk_ready = 0;
            end
            alu_done = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    alu_done   = 1'b1;
                    alu_result = pend;
                    done_cyc   = cyc;
                    if (n_launch <= exp_launch.size()) begin
                        check({name, " hold_a"}, alu_a, exp_launch[n_launch-1].a);
                        check({name, " hold_b"}, alu_b, exp_launch[n_launch-1].b);
                    end
                end
            end
            if (alu_start) begin
                check({name, " start_latency"}, cyc, acc_cyc + 1);
                if (n_launch < exp_launch.size()) begin
                    check({name, " alu_op"}, alu_op, exp_launch[n_launch].op);
                    check({name, " alu_a"}, alu_a, exp_launch[n_launch].a);
                    check({name, " alu_b"}, alu_b, exp_launch[n_launch].b);
                end
                n_launch++;
                pend = alu_model(alu_op, alu_a, alu_b);
                cd   = lat;
            end
            if (res_valid) begin
                got = 1;
                check({name, " res_error"}, res_error, exp_code != 2'b00);
                check({name, " res_err_code"}, res_err_code, exp_code);
                check({name, " res_data"}, res_data, exp_data);
                check({name, " all_tokens_taken"}, idx, toks.size());
                check({name, " res_latency"}, cyc, exp_last_launch ? done_cyc + 1 : acc_last_cyc + 1);
                tok_valid = 1'b0;
            end else if (idx < toks.size()) begin
                tok_valid = 1'b1;
                tok_is_op = toks[idx].is_op;
                tok_code  = toks[idx].code;
                tok_value = toks[idx].value;
                tok_last  = toks[idx].last;
            end else begin
                tok_valid = 1'b0;
            end
            rdy = tok_ready;
            vld = tok_valid;
            @(posedge clock);
            if (vld && rdy) begin
                acc_cyc = cyc;
                if (toks[idx].last) acc_last_cyc = cyc;
                if (!toks[idx].last && !is_arith(toks[idx])) chk_ready = 1;
                idx++;
            end
            @(negedge clock);
            cyc++;
        end
        alu_done = 1'b0;
        tok_valid = 1'b0;
        if (!got) check({name, " timeout"}, 0, 1);
        check({name, " launch_count"}, n_launch, exp_launch.size());
        check({name, " depth_after_done"}, depth, 0);
        check({name, " ready_after_done"}, tok_ready, 1);
    endtask

    initial begin
        int n, r;
        bit last;

        repeat (3) @(negedge clock);
        check("rst tok_ready", tok_ready, 0);
        check("rst alu_start", alu_start, 0);
        check("rst alu_op", alu_op, 0);
        check("rst alu_a", alu_a, 0);
        check("rst alu_b", alu_b, 0);
        check("rst res_valid", res_valid, 0);
        check("rst res_data", res_data, 0);
        check("rst res_error", res_error, 0);
        check("rst res_err_code", res_err_code, 0);
        check("rst depth", depth, 0);
        reset = 1'b1;
        @(negedge clock);
        check("rst release ready", tok_ready, 1);

        toks.delete(); push_opd(F2_0, 0); push_opd(F3_0, 0); push_op(5'h11, 1);
        run_term("add", 2);

        toks.delete(); push_opd(F5_0, 0); push_opd(F3_0, 0); push_op(5'h12, 1);
        run_term("sub", 1);

        toks.delete();
        for (int k = 0; k < 5; k++) push_opd(DW'(k + 1), 0);
        push_op(5'h11, 1);
        run_term("overflow", 1);

        toks.delete(); push_opd(F2_0, 0); push_op(5'h10, 1);
        run_term("underflow", 1);

        toks.delete(); push_opd(F4_0, 0); push_op(5'h15, 0); push_op(5'h10, 1);
        run_term("dup", 3);

        toks.delete(); push_opd(F2_0, 0); push_opd(F3_0, 0); push_op(5'h16, 0); push_op(5'h12, 1);
        run_term("swap", 1);

        toks.delete(); push_opd(F2_0, 0); push_op(5'h1F, 0); push_opd(F3_0, 1);
        run_term("illegal", 1);

        toks.delete(); push_opd(F2_0, 0); push_opd(F3_0, 1);
        run_term("leftover", 1);

        // Abort a term while the ALU is busy; the late alu_done must be ignored.
        toks.delete(); push_opd(F2_0, 0); push_opd(F3_0, 0); push_op(5'h11, 1);
        for (int i = 0; i < 3; i++) begin
            tok_valid = 1'b1;
            tok_is_op = toks[i].is_op;
            tok_code  = toks[i].code;
            tok_value = toks[i].value;
            tok_last  = toks[i].last;
            @(posedge clock);
            @(negedge clock);
        end
        tok_valid = 1'b0;
        check("rst_mid alu_start", alu_start, 1);
        @(posedge clock);
        @(negedge clock);
        check("rst_mid wait ready", tok_ready, 0);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check("rst_mid depth", depth, 0);
        check("rst_mid ready", tok_ready, 0);
        reset      = 1'b1;
        alu_done   = 1'b1;
        alu_result = F5_0;
        @(posedge clock);
        @(negedge clock);
        alu_done = 1'b0;
        check("rst_mid ready_after_release", tok_ready, 1);
        check("rst_mid depth_after_release", depth, 0);
        for (int i = 0; i < 4; i++) begin
            check("rst_mid no_res_valid", res_valid, 0);
            @(posedge clock);
            @(negedge clock);
        end

        for (int t = 0; t < 40; t++) begin
            n = $urandom_range(1, 8);
            toks.delete();
            for (int k = 0; k < n; k++) begin
                last = (k == n - 1);
                r = $urandom_range(0, 9);
                if (r < 5)      push_opd($urandom, last);
                else if (r < 8) push_op(5'h10 + 5'($urandom_range(0, 4)), last);
                else if (r < 9) push_op(5'($urandom_range(21, 22)), last);
                else            push_op(5'($urandom), last);
            end
            run_term("rand", $urandom_range(1, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
